// File: rtl/vita49_ts_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : vita49_ts_pkg
// Brief    : Shared constants for the VITA-49 timestamp generator.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package vita49_ts_pkg;

    localparam int c_nch_default   = 2;
    localparam int c_tsf_w_default = 64;

    // Bit positions inside each channel's 4-bit status field
    localparam int c_st_w       = 4;
    localparam int c_st_running = 0;
    localparam int c_st_pps_miss = 1;
    localparam int c_st_pps_lock = 2;
    localparam int c_st_armed   = 3;

    typedef enum logic {
        MODE_FREE = 1'b0,
        MODE_PPS  = 1'b1
    } ts_mode_e;

endpackage
`default_nettype wire

// File: rtl/vita49_ts_chan.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : vita49_ts_chan
// Brief    : One integer/fractional timestamp channel (free-run or PPS mode).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module vita49_ts_chan
    import vita49_ts_pkg::*;
#(
    parameter int TSF_W = c_tsf_w_default
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_mode_pps,
    input  logic             i_zero_tsf,
    input  logic             i_set_tsi_now,
    input  logic             i_arm_tsi,
    input  logic             i_pps_edge,
    input  logic [31:0]      i_tsi_prog,
    input  logic [31:0]      i_rollover,
    output logic [31:0]      o_tsi,
    output logic [TSF_W-1:0] o_tsf,
    output logic [c_st_w-1:0] o_status
);

    localparam logic [TSF_W-1:0] c_tsf_one = TSF_W'(1);

    logic [31:0]      r_tsi;
    logic [TSF_W-1:0] r_tsf;
    logic             r_armed;
    logic             r_lock;
    logic             r_miss;
    logic             r_running;

    logic [31:0]      w_tsi_nxt;
    logic [TSF_W-1:0] w_tsf_nxt;
    logic             w_armed_nxt;
    logic             w_lock_nxt;
    logic             w_miss_nxt;
    logic             w_miss_set;
    logic             w_cmd;
    logic             w_pps_load;
    logic [TSF_W-1:0] w_roll;
    logic [TSF_W-1:0] w_tsf_inc;
    logic [31:0]      w_tsi_inc;

    assign w_roll     = {{(TSF_W-32){1'b0}}, i_rollover};
    assign w_tsf_inc  = r_tsf + c_tsf_one;
    assign w_tsi_inc  = r_tsi + 32'd1;
    assign w_cmd      = i_set_tsi_now | i_zero_tsf;
    assign w_pps_load = r_armed & i_pps_edge & ~w_cmd;

    always_comb begin
        w_tsi_nxt  = r_tsi;
        w_tsf_nxt  = r_tsf;
        w_miss_set = 1'b0;
        if (w_cmd) begin
            if (i_set_tsi_now) w_tsi_nxt = i_tsi_prog;
            if (i_zero_tsf)    w_tsf_nxt = '0;
        end else if (w_pps_load) begin
            w_tsi_nxt = i_tsi_prog;
            w_tsf_nxt = '0;
        end else if (i_en) begin
            if (i_mode_pps == MODE_PPS) begin
                if (i_pps_edge) begin
                    w_tsf_nxt = '0;
                    w_tsi_nxt = w_tsi_inc;
                end else begin
                    w_tsf_nxt  = (r_tsf >= w_roll) ? r_tsf : w_tsf_inc;
                    w_miss_set = (w_tsf_nxt >= w_roll);
                end
            // '>=' also recovers when rollover is lowered below the live count
            end else if (r_tsf >= w_roll) begin
                w_tsf_nxt = '0;
                w_tsi_nxt = w_tsi_inc;
            end else begin
                w_tsf_nxt = w_tsf_inc;
            end
        end
    end

    always_comb begin
        w_armed_nxt = r_armed;
        if (i_set_tsi_now)   w_armed_nxt = 1'b0;
        else if (i_arm_tsi)  w_armed_nxt = 1'b1;
        else if (w_pps_load) w_armed_nxt = 1'b0;

        w_lock_nxt = r_lock;
        if ((i_mode_pps != MODE_PPS) || w_miss_set) w_lock_nxt = 1'b0;
        else if (i_pps_edge)                        w_lock_nxt = 1'b1;

        w_miss_nxt = r_miss;
        if (w_cmd)           w_miss_nxt = 1'b0;
        else if (w_miss_set) w_miss_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_tsi     <= '0;
            r_tsf     <= '0;
            r_armed   <= 1'b0;
            r_lock    <= 1'b0;
            r_miss    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_tsi     <= w_tsi_nxt;
            r_tsf     <= w_tsf_nxt;
            r_armed   <= w_armed_nxt;
            r_lock    <= w_lock_nxt;
            r_miss    <= w_miss_nxt;
            r_running <= i_en;
        end
    end

    always_comb begin
        o_status                = '0;
        o_status[c_st_running]  = r_running;
        o_status[c_st_pps_miss] = r_miss;
        o_status[c_st_pps_lock] = r_lock;
        o_status[c_st_armed]    = r_armed;
    end

    assign o_tsi = r_tsi;
    assign o_tsf = r_tsf;

endmodule
`default_nettype wire

// File: rtl/vita49_ts_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : vita49_ts_gen
// Brief    : Multi-channel VITA-49 timestamp generator with PPS sync and snapshot.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module vita49_ts_gen
    import vita49_ts_pkg::*;
#(
    parameter int NCH   = c_nch_default,
    parameter int TSF_W = c_tsf_w_default
) (
    input  logic                   samp_clk,
    input  logic                   ARESETN,
    input  logic                   pps_in,
    input  logic [NCH-1:0]         en,
    input  logic [NCH-1:0]         mode_pps,
    input  logic [NCH-1:0]         zero_tsf,
    input  logic [NCH-1:0]         set_tsi_now,
    input  logic [NCH-1:0]         arm_tsi,
    input  logic [31:0]            tsi_prog,
    input  logic [NCH*32-1:0]      rollover,
    input  logic                   snap_req,
    output logic [NCH*32-1:0]      tsi,
    output logic [NCH*TSF_W-1:0]   tsf,
    output logic [NCH*32-1:0]      snap_tsi,
    output logic [NCH*TSF_W-1:0]   snap_tsf,
    output logic                   snap_valid,
    output logic [NCH*c_st_w-1:0]  status,
    output logic                   pps_edge
);

    logic r_pps_meta;
    logic r_pps_sync;
    logic r_pps_q;
    logic r_pps_q_d;
    logic r_pps_edge;

    logic [NCH*32-1:0]    w_tsi;
    logic [NCH*TSF_W-1:0] w_tsf;
    logic [NCH*32-1:0]    r_snap_tsi;
    logic [NCH*TSF_W-1:0] r_snap_tsf;
    logic                 r_snap_valid;

    // Two-flop synchronizer, then a registered level and its delayed copy
    // feeding a registered rising-edge strobe.
    always_ff @(posedge samp_clk) begin
        if (!ARESETN) begin
            r_pps_meta <= 1'b0;
            r_pps_sync <= 1'b0;
            r_pps_q    <= 1'b0;
            r_pps_q_d  <= 1'b0;
            r_pps_edge <= 1'b0;
        end else begin
            r_pps_meta <= pps_in;
            r_pps_sync <= r_pps_meta;
            r_pps_q    <= r_pps_sync;
            r_pps_q_d  <= r_pps_q;
            r_pps_edge <= r_pps_q & ~r_pps_q_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        vita49_ts_chan #(
            .TSF_W (TSF_W)
        ) u_chan (
            .clk           (samp_clk),
            .i_rst_n       (ARESETN),
            .i_en          (en[g]),
            .i_mode_pps    (mode_pps[g]),
            .i_zero_tsf    (zero_tsf[g]),
            .i_set_tsi_now (set_tsi_now[g]),
            .i_arm_tsi     (arm_tsi[g]),
            .i_pps_edge    (r_pps_edge),
            .i_tsi_prog    (tsi_prog),
            .i_rollover    (rollover[g*32 +: 32]),
            .o_tsi         (w_tsi[g*32 +: 32]),
            .o_tsf         (w_tsf[g*TSF_W +: TSF_W]),
            .o_status      (status[g*c_st_w +: c_st_w])
        );
    end

    // All channels are captured on the same edge so the snapshot is coherent
    always_ff @(posedge samp_clk) begin
        if (!ARESETN) begin
            r_snap_tsi   <= '0;
            r_snap_tsf   <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= snap_req;
            if (snap_req) begin
                r_snap_tsi <= w_tsi;
                r_snap_tsf <= w_tsf;
            end
        end
    end

    assign tsi        = w_tsi;
    assign tsf        = w_tsf;
    assign snap_tsi   = r_snap_tsi;
    assign snap_tsf   = r_snap_tsf;
    assign snap_valid = r_snap_valid;
    assign pps_edge   = r_pps_edge;

endmodule
`default_nettype wire
